// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: pre-IF next-PC, fs register, SRAM read port, one-entry inst buffer
// Optional fetch/cancel counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        ds_allowin,
   input  logic [32:0] br_zip,
   output logic        fs2ds_valid,
   output logic [63:0] fs2ds_bus,
   output logic        inst_sram_en,
   output logic [3:0]  inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] cancel_cnt
`endif
);

   logic        rst_done;
   logic        fs_valid;
   logic [31:0] fs_pc;
   logic        inst_buf_valid;
   logic [31:0] inst_buf;

   logic        br_taken;
   logic [31:0] br_target;
   logic        to_fs_valid;
   logic        fs_allowin;
   logic [31:0] seq_pc;
   logic [31:0] nextpc;
   logic [31:0] fs_inst;

   assign br_taken  = br_zip[32];
   assign br_target = br_zip[31:0];

   assign to_fs_valid = rst_done;
   assign seq_pc      = fs_pc + 32'd4;
   assign nextpc      = br_taken ? br_target : seq_pc;
   // A redirect frees fs: decode discards the wrong-path instruction.
   assign fs_allowin  = ~fs_valid | ds_allowin | br_taken;

   assign inst_sram_en    = to_fs_valid & fs_allowin;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_we    = 4'b0000;
   assign inst_sram_wdata = 32'h0000_0000;

   assign fs_inst     = inst_buf_valid ? inst_buf : inst_sram_rdata;
   assign fs2ds_valid = fs_valid & ~br_taken;
   assign fs2ds_bus   = {fs_pc, fs_inst};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rst_done <= 1'b0;
         fs_valid <= 1'b0;
         fs_pc    <= RESET_PC - 32'd4;
      end else begin
         rst_done <= 1'b1;
         if (fs_allowin) begin
            fs_valid <= to_fs_valid;
            if (to_fs_valid) begin
               fs_pc <= nextpc;
            end
         end
      end
   end

   // SRAM data is only valid for one cycle, so hold it while decode stalls.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inst_buf_valid <= 1'b0;
         inst_buf       <= 32'h0000_0000;
      end else if (fs_allowin) begin
         inst_buf_valid <= 1'b0;
      end else if (fs_valid && !inst_buf_valid) begin
         inst_buf_valid <= 1'b1;
         inst_buf       <= inst_sram_rdata;
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_cnt  <= 32'h0000_0000;
         cancel_cnt <= 32'h0000_0000;
      end else begin
         if (fs2ds_valid && ds_allowin) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (fs_valid && br_taken) begin
            cancel_cnt <= cancel_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

   logic        clk;
   logic        resetn;
   logic        ds_allowin;
   logic [32:0] br_zip;
   logic        fs2ds_valid;
   logic [63:0] fs2ds_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_we;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic [31:0] inst_sram_rdata;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] cancel_cnt;
`endif

   int checks = 0;
   int errors = 0;

   if_stage dut (
      .clk(clk),
      .resetn(resetn),
      .ds_allowin(ds_allowin),
      .br_zip(br_zip),
      .fs2ds_valid(fs2ds_valid),
      .fs2ds_bus(fs2ds_bus),
      .inst_sram_en(inst_sram_en),
      .inst_sram_we(inst_sram_we),
      .inst_sram_addr(inst_sram_addr),
      .inst_sram_wdata(inst_sram_wdata),
      .inst_sram_rdata(inst_sram_rdata)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt(fetch_cnt),
      .cancel_cnt(cancel_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9e3779b1) ^ 32'h0f1e2d3c;
   endfunction

   // Synchronous SRAM; non-enabled cycles return garbage to expose lost data.
   always @(posedge clk) begin
      if (inst_sram_en) inst_sram_rdata <= memf(inst_sram_addr);
      else              inst_sram_rdata <= 32'hdeadbeef;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        ds;
      logic        br;
      logic [31:0] tgt;
      logic        v;
      logic        fsv;
      logic [31:0] pc;
      logic        en;
      logic [31:0] addr;
   } vec_t;

   vec_t tbl[13];

   // Reference: the fetch PC held by fs, and expected counts of accepted/cancelled fetches.
   logic        m_started, m_valid;
   logic [31:0] m_pc;
   int unsigned m_fetch, m_cancel;

   task automatic step(input logic ds, input logic br, input logic [31:0] tgt);
      logic free;
      logic [31:0] next;
      @(negedge clk);
      ds_allowin = ds;
      br_zip     = {br, tgt};
      #1;
      free = !m_valid || ds || br;
      next = br ? tgt : m_pc + 32'd4;
      chk("m_valid", {63'd0, fs2ds_valid}, {63'd0, m_valid && !br});
      chk("m_en", {63'd0, inst_sram_en}, {63'd0, m_started && free});
      chk("m_addr", {32'd0, inst_sram_addr}, {32'd0, next});
      chk("m_pc", {32'd0, fs2ds_bus[63:32]}, {32'd0, m_pc});
      if (m_valid) chk("m_inst", {32'd0, fs2ds_bus[31:0]}, {32'd0, memf(m_pc)});
      @(posedge clk);
      if (m_valid && !br && ds) m_fetch++;
      if (m_valid && br) m_cancel++;
      if (free) begin
         m_valid = m_started;
         if (m_started) m_pc = next;
      end
      m_started = 1'b1;
   endtask

   task automatic model_reset();
      m_started = 1'b0;
      m_valid   = 1'b0;
      m_pc      = 32'h1bfffffc;
      m_fetch   = 0;
      m_cancel  = 0;
   endtask

   initial begin
      tbl[0]  = '{1, 0, 32'h0,         0, 0, 32'h1bfffffc, 1, 32'h1c000000};
      tbl[1]  = '{1, 0, 32'h0,         1, 1, 32'h1c000000, 1, 32'h1c000004};
      tbl[2]  = '{1, 0, 32'h0,         1, 1, 32'h1c000004, 1, 32'h1c000008};
      tbl[3]  = '{0, 0, 32'h0,         1, 1, 32'h1c000008, 0, 32'h1c00000c};
      tbl[4]  = '{0, 0, 32'h0,         1, 1, 32'h1c000008, 0, 32'h1c00000c};
      tbl[5]  = '{0, 0, 32'h0,         1, 1, 32'h1c000008, 0, 32'h1c00000c};
      tbl[6]  = '{1, 0, 32'h0,         1, 1, 32'h1c000008, 1, 32'h1c00000c};
      tbl[7]  = '{1, 0, 32'h0,         1, 1, 32'h1c00000c, 1, 32'h1c000010};
      tbl[8]  = '{1, 1, 32'h1c000100,  0, 1, 32'h1c000010, 1, 32'h1c000100};
      tbl[9]  = '{0, 0, 32'h0,         1, 1, 32'h1c000100, 0, 32'h1c000104};
      tbl[10] = '{0, 0, 32'h0,         1, 1, 32'h1c000100, 0, 32'h1c000104};
      tbl[11] = '{0, 1, 32'h1c000200,  0, 1, 32'h1c000100, 1, 32'h1c000200};
      tbl[12] = '{1, 0, 32'h0,         1, 1, 32'h1c000200, 1, 32'h1c000204};

      resetn     = 1'b0;
      ds_allowin = 1'b1;
      br_zip     = 33'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {63'd0, fs2ds_valid}, 64'd0);
      chk("rst_en", {63'd0, inst_sram_en}, 64'd0);
      chk("rst_pc", {32'd0, fs2ds_bus[63:32]}, 64'h1bfffffc);
      chk("rst_we_wdata", {28'd0, inst_sram_we, inst_sram_wdata}, 64'd0);

      resetn = 1'b1;
      #1;
      chk("rel_en", {63'd0, inst_sram_en}, 64'd0);

      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         ds_allowin = tbl[i].ds;
         br_zip     = {tbl[i].br, tbl[i].tgt};
         #1;
         chk($sformatf("t%0d_valid", i), {63'd0, fs2ds_valid}, {63'd0, tbl[i].v});
         chk($sformatf("t%0d_pc", i), {32'd0, fs2ds_bus[63:32]}, {32'd0, tbl[i].pc});
         chk($sformatf("t%0d_en", i), {63'd0, inst_sram_en}, {63'd0, tbl[i].en});
         chk($sformatf("t%0d_addr", i), {32'd0, inst_sram_addr}, {32'd0, tbl[i].addr});
         if (tbl[i].fsv)
            chk($sformatf("t%0d_inst", i), {32'd0, fs2ds_bus[31:0]}, {32'd0, memf(tbl[i].pc)});
      end

      // Reset asserted between edges must drop outputs immediately.
      @(negedge clk);
      ds_allowin = 1'b1;
      br_zip     = 33'd0;
      #1;
      chk("pre_rst_en", {63'd0, inst_sram_en}, 64'd1);
      chk("pre_rst_valid", {63'd0, fs2ds_valid}, 64'd1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_valid", {63'd0, fs2ds_valid}, 64'd0);
      chk("mid_rst_en", {63'd0, inst_sram_en}, 64'd0);
      chk("mid_rst_pc", {32'd0, fs2ds_bus[63:32]}, 64'h1bfffffc);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
      @(posedge clk);
      m_started = 1'b1;

      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] t;
         t = $urandom;
         step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, {t[31:2], 2'b00});
      end
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

`ifdef IF_PERF_CNT_EN
      @(negedge clk);
      chk("fetch_cnt", {32'd0, fetch_cnt}, {32'd0, m_fetch});
      chk("cancel_cnt", {32'd0, cancel_cnt}, {32'd0, m_cancel});
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
